anneal_ctrl: RTL and testbench
==============================

Name: anneal_ctrl

Overview:
- Clocked run controller for the asynchronous oscillator array (core_matrix, N spins).
- Holds a host-writable upper-triangle coupling-weight bank and drives it to the matrix.
- Sequences matrix reset, settle and sample phases, then resolves each oscillator's phase relative to oscillator 0 into a spin vector.
- Sits between the host/config logic and core_matrix; the matrix itself stays outside this block.

Parameters:
- N, 3: spin (oscillator) count, at least 2; P = N*(N-1)/2 couplings.
- NUM_WEIGHTS, 5: distinct weight levels; WW = $clog2(NUM_WEIGHTS) bits per weight.
- RST_CYCLES, 4: cycles mat_rstn is held low at run start, at least 1.
- SAMPLE_CYCLES, 16: cycles of phase comparison per run, at least 1.
- RUN_W, 16: width of run_cycles.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- cfg_valid  in  1  weight write request.
- cfg_ready  out  1  weight write accepted when cfg_valid and cfg_ready are both high.
- cfg_addr  in  $clog2(P)  coupling index k. Pairs are ordered j outer (1..N-1), i inner (0..j-1); for N=3: 0=(0,1), 1=(0,2), 2=(1,2).
- cfg_data  in  WW  weight level.
- start  in  1  begin run; sampled only in IDLE.
- abort  in  1  cancel run.
- run_cycles  in  RUN_W  settle length; latched at start.
- busy  out  1  high in all states except IDLE.
- done  out  1  one-cycle pulse when spins are updated.
- spins  out  N  bit i = 1 means oscillator i is anti-phase to oscillator 0; bit 0 is always 0.
- mat_rstn  out  1  matrix reset, active low.
- mat_weights  out  P*WW  weight k occupies bits [k*WW +: WW].
- mat_outputs  in  N  asynchronous oscillator outputs.

Behaviour:
- Reset values:
  - state IDLE; busy 0; done 0; spins 0; mat_rstn 0.
  - Every weight = NUM_WEIGHTS/2 (integer division; the neutral/no-coupling level, 3'b010 for 5 levels).
  - Counters 0.
- Synchroniser: mat_outputs passes through a 2-flop synchroniser per bit; reset value 0. All comparisons use the synchronised value s[i].
- cfg_ready = (state == IDLE).
  - Write takes effect the next cycle.
  - cfg_addr >= P: accepted and dropped.
  - cfg_data >= NUM_WEIGHTS: clamped to NUM_WEIGHTS-1.
- FSM states and transitions:
  - IDLE: start -> HOLD; latch run_cycles; clear agreement counters. Writes and start in the same cycle: write lands; the run uses the new weight.
  - HOLD: mat_rstn 0 for exactly RST_CYCLES cycles, then -> SETTLE, or -> SAMPLE if the latched run_cycles == 0.
  - SETTLE: mat_rstn 1 for run_cycles cycles -> SAMPLE.
  - SAMPLE: mat_rstn 1 for SAMPLE_CYCLES cycles. Each cycle, for i = 1..N-1, agree[i] += (s[i] == s[0]). Counter width is $clog2(SAMPLE_CYCLES+1); it cannot overflow. -> DONE.
  - DONE: one cycle. done = 1; spins[i] = (2*agree[i] < SAMPLE_CYCLES) for i >= 1, so a tie resolves to 0. mat_rstn 0. -> IDLE.
- mat_rstn is 0 in IDLE, HOLD and DONE, and 1 in SETTLE and SAMPLE.
- Latency, start high in cycle t: HOLD t+1..t+RST_CYCLES, SETTLE next run_cycles cycles, SAMPLE next SAMPLE_CYCLES cycles, done at t+1+RST_CYCLES+run_cycles+SAMPLE_CYCLES.
- spins holds its value between runs; it changes only in DONE.
- abort in any non-IDLE state:
  - Next cycle: IDLE, mat_rstn 0, no done pulse, spins unchanged.
  - abort has priority over start and over a phase transition in the same cycle.
  - abort in IDLE has no effect.
- start while busy is ignored; it is not queued.
- rstn low mid-run: all state returns to reset values next edge, including the weight bank.
- run_cycles changes after start do not affect the current run.

Decomposition:
- Shared package anneal_pkg holds:
  - State encoding (IDLE, HOLD, SETTLE, SAMPLE, DONE).
  - Helper function mapping pair (i,j) to index k, reused by core_matrix wiring and test benches.
  - Neutral-weight constant.
- One sub-module: phase_agree.
  - Per-oscillator synchroniser, agreement counter and majority decision.
  - Instantiated for i = 1..N-1 with oscillator 0's synchronised bit shared.

Test Plan (N=3, NUM_WEIGHTS=5, RST_CYCLES=4, SAMPLE_CYCLES=16):
- Reset then no writes -> mat_weights = 9'b010_010_010, mat_rstn 0, cfg_ready 1, spins 3'b000.
- Write k0=4, k1=2, k2=2, then k=3 data=1 (dropped), then k1=7 (clamped) -> mat_weights = 9'b010_100_100.
- start at t with run_cycles=0; model drives osc1 = osc0, osc2 = ~osc0, toggling every 3 cycles -> mat_rstn 1 during t+5..t+20, done at t+21 only, spins = 3'b100, busy low at t+22.
- run_cycles=10; osc1 equal to osc0 for exactly 8 of the 16 sampled cycles (tie), osc2 equal for 3 -> done at t+31, spins = 3'b100.
- abort during SETTLE -> IDLE next cycle, mat_rstn 0, no done, spins retain the previous value. start pulsed while busy in the following run -> done pulses once.
- rstn low during SAMPLE -> weights return to neutral, spins 0, busy 0, no done. A cfg write is accepted on the first cycle after release.

Source files
------------

// File: rtl/anneal_pkg.sv
// Shared types and helpers for the anneal run controller.
// The matrix wiring and the test benches also use these helpers.
package anneal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Coupling pair (i,j), i < j, to flat index k: j outer, i inner.
    function automatic int pair_index(input int i, input int j);
        return (j * (j - 1)) / 2 + i;
    endfunction

    // Middle level of the weight range means no coupling.
    function automatic int neutral_weight(input int num_weights);
        return num_weights / 2;
    endfunction

endpackage

// File: rtl/anneal_ctrl_if.sv
// Host-side coupling-weight write channel (valid/ready).
interface anneal_ctrl_if #(
    parameter int AW = 2,
    parameter int DW = 3
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/anneal_ctrl_phase_agree.sv
// One oscillator's synchroniser, agreement counter against oscillator 0,
// and majority decision over the sample window.
module phase_agree #(
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_osc,
    input  logic i_ref_sync,
    input  logic i_clear,
    input  logic i_sample,
    output logic o_spin
);
    localparam int CW = $clog2(SAMPLE_CYCLES + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_agree;
    logic [CW-1:0] w_agree_nxt;
    logic          w_hit;

    assign w_hit       = i_sample && (r_sync[1] == i_ref_sync);
    assign w_agree_nxt = r_agree + CW'(w_hit);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync  <= '0;
            r_agree <= '0;
        end else begin
            r_sync <= {r_sync[0], i_osc};
            if (i_clear) r_agree <= '0;
            else         r_agree <= w_agree_nxt;
        end
    end

    // Decision includes the current cycle's sample; a tie stays in-phase.
    assign o_spin = (2 * 32'(w_agree_nxt)) < SAMPLE_CYCLES;

endmodule

// File: rtl/anneal_ctrl.sv
// Run controller for the oscillator array: weight bank, reset/settle/sample
// sequencing and spin resolution relative to oscillator 0.
//   state  | meaning
//   IDLE   | waiting for start, weight writes accepted, matrix held in reset
//   HOLD   | matrix reset for RST_CYCLES
//   SETTLE | matrix free-running for the latched run_cycles
//   SAMPLE | counting per-oscillator phase agreement for SAMPLE_CYCLES
//   DONE   | spins updated, done pulse, matrix back in reset
module anneal_ctrl
    import anneal_pkg::*;
#(
    parameter int N             = 3,
    parameter int NUM_WEIGHTS   = 5,
    parameter int RST_CYCLES    = 4,
    parameter int SAMPLE_CYCLES = 16,
    parameter int RUN_W         = 16,
    localparam int P            = N * (N - 1) / 2,
    localparam int WW           = $clog2(NUM_WEIGHTS)
) (
    input  logic             clk,
    input  logic             rstn,
    anneal_ctrl_if.slave     cfg,
    input  logic             start,
    input  logic             abort,
    input  logic [RUN_W-1:0] run_cycles,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     spins,
    output logic             mat_rstn,
    output logic [P*WW-1:0]  mat_weights,
    input  logic [N-1:0]     mat_outputs
);
    localparam int CNT_W = max_int(RUN_W, max_int($clog2(RST_CYCLES + 1), $clog2(SAMPLE_CYCLES + 1)));
    localparam logic [WW-1:0] W_NEUTRAL = WW'(neutral_weight(NUM_WEIGHTS));
    localparam logic [WW-1:0] W_MAX     = WW'(NUM_WEIGHTS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [RUN_W-1:0] r_run_cycles;
    logic [WW-1:0]    r_weights [P];
    logic [N-1:0]     r_spins;
    logic [1:0]       r_sync0;
    logic [N-1:0]     w_spin;
    logic             w_tc;
    logic             w_start_acc;
    logic             w_cfg_wr;
    logic             w_sampling;
    logic             w_resolve;

    assign w_tc        = (r_cnt == '0);
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_cfg_wr    = (r_state == ST_IDLE) && cfg.cfg_valid;
    assign w_sampling  = (r_state == ST_SAMPLE);
    assign w_resolve   = (r_state == ST_SAMPLE) && (w_state_nxt == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_HOLD;
            ST_HOLD:   if (w_tc) w_state_nxt = (r_run_cycles == '0) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE: if (w_tc) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: if (w_tc) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        // abort overrides any phase transition
        if (abort && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        mat_rstn      = 1'b0;
        cfg.cfg_ready = 1'b0;
        case (r_state)
            ST_IDLE:   cfg.cfg_ready = 1'b1;
            ST_HOLD:   busy = 1'b1;
            ST_SETTLE: begin busy = 1'b1; mat_rstn = 1'b1; end
            ST_SAMPLE: begin busy = 1'b1; mat_rstn = 1'b1; end
            ST_DONE:   begin busy = 1'b1; done = 1'b1; end
            default:   cfg.cfg_ready = 1'b0;
        endcase
    end

    // Phase timer: loaded with length-1 on entry, leaves the phase at zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                ST_HOLD:   r_cnt <= CNT_W'(RST_CYCLES - 1);
                ST_SETTLE: r_cnt <= CNT_W'(r_run_cycles - RUN_W'(1));
                ST_SAMPLE: r_cnt <= CNT_W'(SAMPLE_CYCLES - 1);
                default:   r_cnt <= '0;
            endcase
        end else if (!w_tc) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_run_cycles <= '0;
            r_spins      <= '0;
            r_sync0      <= '0;
        end else begin
            r_sync0 <= {r_sync0[0], mat_outputs[0]};
            if (w_start_acc) r_run_cycles <= run_cycles;
            if (w_resolve)   r_spins      <= w_spin;
        end
    end

    // Out-of-range addresses are accepted and dropped; levels clamp to the top.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < P; k++) r_weights[k] <= W_NEUTRAL;
        end else if (w_cfg_wr) begin
            for (int k = 0; k < P; k++) begin
                if (32'(cfg.cfg_addr) == k)
                    r_weights[k] <= (32'(cfg.cfg_data) >= NUM_WEIGHTS) ? W_MAX : cfg.cfg_data;
            end
        end
    end

    for (genvar gk = 0; gk < P; gk++) begin : g_wflat
        assign mat_weights[gk*WW +: WW] = r_weights[gk];
    end

    assign w_spin[0] = 1'b0;
    for (genvar gi = 1; gi < N; gi++) begin : g_osc
        phase_agree #(.SAMPLE_CYCLES(SAMPLE_CYCLES)) u_agree (
            .clk        (clk),
            .rstn       (rstn),
            .i_osc      (mat_outputs[gi]),
            .i_ref_sync (r_sync0[1]),
            .i_clear    (w_start_acc),
            .i_sample   (w_sampling),
            .o_spin     (w_spin[gi])
        );
    end

    assign spins = r_spins;

endmodule

// File: tb/tb_anneal_ctrl.sv
// Self-checking bench for anneal_ctrl: weight bank, run timing, spin
// resolution, abort and reset behaviour against a cycle-offset model.
module tb_anneal_ctrl;
    import anneal_pkg::*;

    localparam int N     = 3;
    localparam int NW    = 5;
    localparam int R     = 4;
    localparam int S     = 16;
    localparam int RUN_W = 16;
    localparam int P     = 3;
    localparam int WW    = 3;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [RUN_W-1:0] run_cycles = '0;
    logic             busy;
    logic             done;
    logic [N-1:0]     spins;
    logic             mat_rstn;
    logic [P*WW-1:0]  mat_weights;
    logic [N-1:0]     mat_outputs = '0;

    anneal_ctrl_if #(.AW(AW), .DW(WW)) cfg_if();

    anneal_ctrl #(
        .N(N), .NUM_WEIGHTS(NW), .RST_CYCLES(R), .SAMPLE_CYCLES(S), .RUN_W(RUN_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg         (cfg_if),
        .start       (start),
        .abort       (abort),
        .run_cycles  (run_cycles),
        .busy        (busy),
        .done        (done),
        .spins       (spins),
        .mat_rstn    (mat_rstn),
        .mat_weights (mat_weights),
        .mat_outputs (mat_outputs)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           exp_w [P];
    logic [N-1:0] exp_spins = '0;

    function automatic logic [P*WW-1:0] packed_w();
        logic [P*WW-1:0] v;
        v = '0;
        for (int k = 0; k < P; k++) v[k*WW +: WW] = WW'(exp_w[k]);
        return v;
    endfunction

    // mode 0: osc1 = osc0, osc2 = ~osc0, toggling every 3 cycles
    // mode 1: osc1 agrees for 8 sampled cycles, osc2 for 3
    // mode 2: fully random
    function automatic logic [N-1:0] gen_osc(input int mode, input int o, input int s_start);
        logic b;
        logic b1;
        logic b2;
        int   idx;
        if (mode == 0) begin
            b = ((o / 3) % 2) == 1;
            return {~b, b, b};
        end else if (mode == 1) begin
            b   = $urandom_range(0, 1) == 1;
            idx = o + 2 - s_start;
            b1  = (idx >= 0 && idx < 8) ? b : ~b;
            b2  = (idx >= 0 && idx < 3) ? b : ~b;
            return {b2, b1, b};
        end
        return N'($urandom_range(0, 7));
    endfunction

    task automatic cfg_write(input string name, input int addr, input int data);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = AW'(addr);
        cfg_if.cfg_data  = WW'(data);
        @(negedge clk);
        n_tests++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s cfg_ready got %b want 1", name, cfg_if.cfg_ready);
        end
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
        if (addr < P) exp_w[addr] = (data >= NW) ? NW - 1 : data;
        @(negedge clk);
        n_tests++;
        if (mat_weights !== packed_w()) begin
            n_fail++;
            $display("FAIL %s mat_weights got %b want %b", name, mat_weights, packed_w());
        end
        @(posedge clk); #1;
    endtask

    // One run started at offset 0; every cycle's outputs are checked against
    // the phase implied by the offset. abort_off/extra_start_off < 0 = unused.
    task automatic do_run(input string name, input int run_len, input int mode,
                          input int abort_off, input int extra_start_off);
        logic [N-1:0] hist [0:127];
        logic [N-1:0] new_spins;
        logic [N-1:0] want_spins;
        logic         want_busy;
        logic         want_rstn;
        logic         want_done;
        int           s_start;
        int           done_off;
        int           end_off;
        int           agree;
        int           ph;
        bit           aborted;
        s_start  = 1 + R + run_len;
        done_off = s_start + S;
        aborted  = (abort_off > 0) && (abort_off < done_off);
        end_off  = aborted ? abort_off + 3 : done_off + 3;
        for (int o = 0; o <= end_off; o++) hist[o] = gen_osc(mode, o, s_start);
        new_spins = '0;
        for (int i = 1; i < N; i++) begin
            agree = 0;
            for (int o = s_start; o < done_off; o++)
                if (hist[o-2][i] == hist[o-2][0]) agree++;
            new_spins[i] = (2 * agree) < S;
        end
        for (int o = 0; o <= end_off; o++) begin
            start       = (o == 0) || (o == extra_start_off);
            run_cycles  = (o == 0) ? RUN_W'(run_len) : RUN_W'($urandom_range(0, 3));
            abort       = (o == abort_off);
            mat_outputs = hist[o];
            @(negedge clk);
            if (o == 0 || o > done_off || (aborted && o > abort_off)) ph = 0;
            else if (o <= R)                                      ph = 1;
            else if (o < s_start)                                 ph = 2;
            else if (o < done_off)                                ph = 3;
            else                                                  ph = 4;
            want_busy  = (ph != 0);
            want_rstn  = (ph == 2) || (ph == 3);
            want_done  = (ph == 4);
            want_spins = (!aborted && o >= done_off) ? new_spins : exp_spins;
            n_tests++;
            if (busy !== want_busy) begin
                n_fail++;
                $display("FAIL %s busy o=%0d got %b want %b", name, o, busy, want_busy);
            end
            n_tests++;
            if (mat_rstn !== want_rstn) begin
                n_fail++;
                $display("FAIL %s mat_rstn o=%0d got %b want %b", name, o, mat_rstn, want_rstn);
            end
            n_tests++;
            if (done !== want_done) begin
                n_fail++;
                $display("FAIL %s done o=%0d got %b want %b", name, o, done, want_done);
            end
            n_tests++;
            if (spins !== want_spins) begin
                n_fail++;
                $display("FAIL %s spins o=%0d got %b want %b", name, o, spins, want_spins);
            end
            n_tests++;
            if (cfg_if.cfg_ready !== !want_busy) begin
                n_fail++;
                $display("FAIL %s cfg_ready o=%0d got %b want %b", name, o, cfg_if.cfg_ready, !want_busy);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        if (!aborted) exp_spins = new_spins;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < P; k++) exp_w[k] = neutral_weight(NW);
        exp_spins = '0;
        @(negedge clk);
        n_tests++;
        if (mat_weights !== 9'b010_010_010) begin
            n_fail++;
            $display("FAIL reset mat_weights got %b want %b", mat_weights, 9'b010_010_010);
        end
        n_tests++;
        if ({busy, done, mat_rstn, cfg_if.cfg_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset busy/done/rstn/ready got %b want 0001", {busy, done, mat_rstn, cfg_if.cfg_ready});
        end
        n_tests++;
        if (spins !== 3'b000) begin
            n_fail++;
            $display("FAIL reset spins got %b want 000", spins);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cfg_writes();
        cfg_write("w_k0", pair_index(0, 1), 4);
        cfg_write("w_k1", pair_index(0, 2), 2);
        cfg_write("w_k2", pair_index(1, 2), 2);
        cfg_write("w_drop", 3, 1);
        cfg_write("w_clamp", 1, 7);
        @(negedge clk);
        n_tests++;
        if (mat_weights !== 9'b010_100_100) begin
            n_fail++;
            $display("FAIL cfg_plan mat_weights got %b want %b", mat_weights, 9'b010_100_100);
        end
        @(posedge clk); #1;
        for (int n = 0; n < 8; n++)
            cfg_write("w_rand", $urandom_range(0, 3), $urandom_range(0, 7));
    endtask

    task automatic test_run_zero_settle();
        do_run("run0", 0, 0, -1, -1);
        n_tests++;
        if (spins !== 3'b100) begin
            n_fail++;
            $display("FAIL run0_spins got %b want 100", spins);
        end
    endtask

    task automatic test_tie();
        do_run("pre_tie", 4, 2, -1, -1);
        do_run("tie", 10, 1, -1, -1);
        n_tests++;
        if (spins !== 3'b100) begin
            n_fail++;
            $display("FAIL tie_spins got %b want 100", spins);
        end
    endtask

    task automatic test_abort();
        do_run("abort_settle", 6, 2, R + 3, -1);
        do_run("busy_start", 3, 2, -1, 10);
        do_run("abort_hold_end", 5, 2, R, -1);
        do_run("abort_sample_end", 2, 2, 1 + R + 2 + S - 1, -1);
        do_run("abort_idle", 1, 2, 0, -1);
    endtask

    task automatic test_write_with_start();
        start = 1'b1;
        run_cycles = 16'd5;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = 2'd2;
        cfg_if.cfg_data  = 3'd0;
        @(negedge clk);
        n_tests++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ws_ready got %b want 1", cfg_if.cfg_ready);
        end
        @(posedge clk); #1;
        start = 1'b0;
        exp_w[2] = 0;
        cfg_if.cfg_data = 3'd4;
        @(negedge clk);
        n_tests++;
        if (mat_weights !== packed_w()) begin
            n_fail++;
            $display("FAIL ws_weights got %b want %b", mat_weights, packed_w());
        end
        n_tests++;
        if ({busy, cfg_if.cfg_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL ws_busy got %b want 10", {busy, cfg_if.cfg_ready});
        end
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mat_weights !== packed_w()) begin
            n_fail++;
            $display("FAIL ws_busy_write got %b want %b", mat_weights, packed_w());
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ws_abort busy got %b want 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_runs();
        int rl;
        int d;
        int ab;
        int ex;
        for (int n = 0; n < 6; n++) begin
            rl = $urandom_range(0, 12);
            d  = 1 + R + rl + S;
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, d - 1) : -1;
            ex = ($urandom_range(0, 1) == 0) ? $urandom_range(1, d - 1) : -1;
            if (ab > 0 && ex > ab) ex = -1;
            do_run("rand", rl, 2, ab, ex);
        end
    endtask

    task automatic test_reset_mid_run();
        do_run("pre_rst", 0, 0, -1, -1);
        for (int o = 0; o <= 1 + R + 2 + 4; o++) begin
            start       = (o == 0);
            run_cycles  = 16'd2;
            mat_outputs = N'($urandom_range(0, 7));
            rstn        = (o != 1 + R + 2 + 4);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rstn  = 1'b1;
        for (int k = 0; k < P; k++) exp_w[k] = neutral_weight(NW);
        exp_spins = '0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_data  = 3'd1;
        @(negedge clk);
        n_tests++;
        if (mat_weights !== packed_w()) begin
            n_fail++;
            $display("FAIL rst_mid weights got %b want %b", mat_weights, packed_w());
        end
        n_tests++;
        if ({busy, done, mat_rstn, cfg_if.cfg_ready, spins} !== {4'b0001, exp_spins}) begin
            n_fail++;
            $display("FAIL rst_mid state got %b want %b", {busy, done, mat_rstn, cfg_if.cfg_ready, spins}, {4'b0001, exp_spins});
        end
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
        exp_w[0] = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if ({mat_weights, done, busy} !== {packed_w(), 2'b00}) begin
                n_fail++;
                $display("FAIL rst_mid after c=%0d got %b want %b", c, {mat_weights, done, busy}, {packed_w(), 2'b00});
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_data  = '0;
        test_reset();
        test_cfg_writes();
        test_run_zero_settle();
        test_tie();
        test_abort();
        test_write_with_start();
        test_random_runs();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
